// File: rtl/sapho_pkg.sv
// Shared definitions for the processor blocks around the prefetch stage.
// Holds the flow-control opcodes, the interrupt sequencer state encoding,
// and a constant-safe clog2 helper used to size index ports.
package sapho_pkg;

    // Opcodes that load the PC; the core uses them to build the branch strobe.
    localparam logic [3:0] OP_JMP = 4'd12;
    localparam logic [3:0] OP_JIZ = 4'd13;
    localparam logic [3:0] OP_CAL = 4'd14;
    localparam logic [3:0] OP_RET = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_SERVICE = 2'd2
    } itr_state_e;

    // Bits needed to index n items, never less than 1 so a single
    // source still gets a real port.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++)
            if ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index priority encoder.
//   vec_i   : request vector
//   valid_o : any bit of vec_i set
//   idx_o   : index of the lowest set bit (0 when none set)
module prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        // Scan high to low so the last hit, the lowest index, sticks.
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) idx_o = IW'(i);
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/itr_ctrl.sv
// Vectored interrupt sequencer for the core's itr input.
// Latches rising edges on req_i, gates them with a mask and gie, and fires
// a one-cycle itr_o with the vector address of the lowest pending source.
// Interrupts are non-nested: after a fire nothing else is taken until the
// RET that unwinds the call depth back to the ISR's entry level.
//   clk_i, rst_i      : clock, synchronous active-low reset
//   req_i             : edge-sensitive request lines
//   gie_i             : global interrupt enable
//   mask_we_i/din_i   : mask register write port
//   branch_i          : current instruction loads the PC (defers a fire)
//   isp_push_i/pop_i  : return-stack strobes (CAL/RET)
//   itr_o, itr_addr_o : fire strobe and vector address
//   in_service_o      : ISR active
//   itr_id_o          : source being / last serviced
//   pend_o, mask_o    : pending flags and mask register
module itr_ctrl
    import sapho_pkg::*;
#(
    parameter int                NITR    = 4,
    parameter int                MINSTW  = 8,
    parameter logic [MINSTW-1:0] ITRADD  = '0,
    parameter int                ITRSTEP = 4,
    parameter int                DEPW    = 5,
    localparam int               IDW     = clog2(NITR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NITR-1:0]   req_i,
    input  logic              gie_i,
    input  logic              mask_we_i,
    input  logic [NITR-1:0]   mask_din_i,
    input  logic              branch_i,
    input  logic              isp_push_i,
    input  logic              isp_pop_i,
    output logic              itr_o,
    output logic [MINSTW-1:0] itr_addr_o,
    output logic              in_service_o,
    output logic [IDW-1:0]    itr_id_o,
    output logic [NITR-1:0]   pend_o,
    output logic [NITR-1:0]   mask_o
);

    itr_state_e        state_q, state_d;
    logic [NITR-1:0]   req_q, pend_q, pend_d, mask_q;
    logic [IDW-1:0]    itr_id_q, sel;
    logic [DEPW-1:0]   depth_q, depth_d, entry_depth_q;
    logic              any_sel, eligible, itr;
    logic [NITR-1:0]   clr;

    prio_enc #(.N(NITR), .IW(IDW)) u_prio (
        .vec_i   (pend_q & mask_q),
        .valid_o (any_sel),
        .idx_o   (sel)
    );

    assign eligible = gie_i & any_sel;
    // A fire is deferred while the current instruction redirects the PC,
    // otherwise the saved return address would be wrong.
    assign itr      = (state_q == ST_ARM) & ~branch_i & eligible;

    assign clr    = itr ? (NITR'(1) << sel) : '0;
    // A fresh edge on the bit being cleared must not be lost: set wins.
    assign pend_d = (pend_q & ~clr) | (req_i & ~req_q);

    // itr counts as a push: the core stacks the return address on entry.
    assign depth_d = depth_q + DEPW'(isp_push_i | itr) - DEPW'(isp_pop_i);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (eligible) state_d = ST_ARM;
            ST_ARM: begin
                if (itr)            state_d = ST_SERVICE;
                else if (!eligible) state_d = ST_IDLE;
            end
            ST_SERVICE: if (isp_pop_i && depth_q == entry_depth_q) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            req_q         <= req_i;   // level already high is not an edge
            pend_q        <= '0;
            mask_q        <= '0;
            itr_id_q      <= '0;
            depth_q       <= '0;
            entry_depth_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_i;
            pend_q  <= pend_d;
            depth_q <= depth_d;
            if (mask_we_i) mask_q <= mask_din_i;
            if (itr) begin
                itr_id_q      <= sel;
                entry_depth_q <= depth_q + DEPW'(1);
            end
        end
    end

    assign itr_o        = itr;
    assign itr_addr_o   = itr ? ITRADD + MINSTW'(sel) * MINSTW'(ITRSTEP) : ITRADD;
    assign in_service_o = (state_q == ST_SERVICE);
    assign itr_id_o     = itr_id_q;
    assign pend_o       = pend_q;
    assign mask_o       = mask_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed bench for itr_ctrl: every fire is checked by a monitor against a
// queue of expected vector addresses; state outputs are checked inline.
module tb_itr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic       gie = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_din = '0;
    logic       branch = 1'b0;
    logic       isp_push = 1'b0;
    logic       isp_pop = 1'b0;
    logic       itr;
    logic [7:0] itr_addr;
    logic       in_service;
    logic [1:0] itr_id;
    logic [3:0] pend;
    logic [3:0] mask;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    itr_ctrl #(.NITR(4), .MINSTW(8), .ITRADD(8'd0), .ITRSTEP(4), .DEPW(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .gie_i        (gie),
        .mask_we_i    (mask_we),
        .mask_din_i   (mask_din),
        .branch_i     (branch),
        .isp_push_i   (isp_push),
        .isp_pop_i    (isp_pop),
        .itr_o        (itr),
        .itr_addr_o   (itr_addr),
        .in_service_o (in_service),
        .itr_id_o     (itr_id),
        .pend_o       (pend),
        .mask_o       (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_din = m;
        tick();
        mask_we = 1'b0;
    endtask

    // One-cycle RET strobe (ISR exit or nested return).
    task automatic ret();
        isp_pop = 1'b1;
        tick();
        isp_pop = 1'b0;
    endtask

    initial begin
        // Monitor: every fire must match the oldest expected vector.
        fork
            forever begin
                @(negedge clk);
                if (rst && itr === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_itr: got addr %0h expected no fire", itr_addr);
                    end else begin
                        chk("itr_addr", 32'(itr_addr), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        // Reset with all requests high: no edges may be recorded.
        req = 4'hF;
        tick(2);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_mask", 32'(mask), 0);
        chk("rst_itr", 32'(itr), 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_itr_id", 32'(itr_id), 0);
        rst = 1'b1;
        tick(3);
        chk("no_edge_pend", 32'(pend), 0);
        req = '0;
        tick();

        // Basic fire on source 2.
        set_mask(4'b0100);
        gie = 1'b1;
        exp_q.push_back(8'd8);
        req[2] = 1'b1;
        tick();
        req = '0;
        chk("basic_pend_set", 32'(pend), 32'h4);
        chk("basic_no_itr_yet", 32'(itr), 0);
        tick();
        chk("basic_itr", 32'(itr), 1);
        tick();
        chk("basic_in_service", 32'(in_service), 1);
        chk("basic_itr_id", 32'(itr_id), 2);
        chk("basic_pend_clr", 32'(pend), 0);
        ret();
        chk("basic_exit", 32'(in_service), 0);

        // Priority with branch deferral: sources 1 and 3 together.
        set_mask(4'hF);
        branch = 1'b1;
        req = 4'b1010;
        tick();
        req = '0;
        chk("prio_pend", 32'(pend), 32'hA);
        tick();
        chk("defer_itr_0", 32'(itr), 0);
        tick();
        chk("defer_itr_1", 32'(itr), 0);
        exp_q.push_back(8'd4);
        branch = 1'b0;
        #1;
        chk("prio_itr", 32'(itr), 1);
        tick();
        chk("prio_id", 32'(itr_id), 1);
        chk("prio_pend3_kept", 32'(pend), 32'h8);

        // Nested CAL/CAL/RET/RET inside the ISR; third RET exits.
        isp_push = 1'b1;
        tick(2);
        isp_push = 1'b0;
        ret();
        ret();
        chk("nested_still_in", 32'(in_service), 1);
        exp_q.push_back(8'd12);
        ret();
        chk("nested_exit", 32'(in_service), 0);
        tick();
        chk("src3_itr", 32'(itr), 1);
        tick();
        chk("src3_id", 32'(itr_id), 3);
        chk("src3_pend_clr", 32'(pend), 0);
        ret();

        // Masked source still latches; enabling the mask fires it.
        set_mask(4'b0000);
        req[0] = 1'b1;
        tick();
        req = '0;
        tick(3);
        chk("masked_pend", 32'(pend), 32'h1);
        chk("masked_no_itr", 32'(itr), 0);
        exp_q.push_back(8'd0);
        set_mask(4'b0001);
        tick();
        chk("unmask_itr", 32'(itr), 1);
        tick();
        ret();

        // gie low holds a pending, enabled source.
        set_mask(4'hF);
        gie = 1'b0;
        req[1] = 1'b1;
        tick();
        req = '0;
        tick(4);
        chk("gie_pend", 32'(pend), 32'h2);
        chk("gie_no_itr", 32'(itr), 0);
        exp_q.push_back(8'd4);
        gie = 1'b1;
        tick();
        chk("gie_itr", 32'(itr), 1);
        tick();
        ret();

        // Reset while an ISR (with an extra CAL) is active.
        exp_q.push_back(8'd0);
        req[0] = 1'b1;
        tick();
        req = '0;
        tick(2);
        chk("mid_in_service", 32'(in_service), 1);
        isp_push = 1'b1;
        tick();
        isp_push = 1'b0;
        rst = 1'b0;
        tick();
        chk("mid_rst_in_service", 32'(in_service), 0);
        chk("mid_rst_id", 32'(itr_id), 0);
        chk("mid_rst_mask", 32'(mask), 0);
        rst = 1'b1;
        set_mask(4'b0001);
        exp_q.push_back(8'd0);
        req[0] = 1'b1;
        tick();
        req = '0;
        tick();
        chk("post_rst_itr", 32'(itr), 1);
        tick();
        chk("post_rst_in_service", 32'(in_service), 1);
        ret();
        chk("post_rst_exit", 32'(in_service), 0);

        tick(3);
        chk("all_fires_seen", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
- Vectored interrupt controller that sequences the processor's `itr` input.
- Latches edge-triggered requests from NITR sources, applies a mask, and picks the lowest-index pending source.
- Fires a one-cycle `itr` into the prefetch stage together with the vector address, then blocks further interrupts until the ISR's matching RET.
- Sits beside the prefetch stage; the return-address stack's push/pop strobes are used to track call depth.

Parameters:
- NITR, 4, number of interrupt request lines (1..16).
- MINSTW, 8, instruction address width.
- ITRADD, 0, vector address of source 0 (MINSTW bits).
- ITRSTEP, 4, address distance between consecutive vectors.
- DEPW, 5, width of the call-depth counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- req  in  NITR  interrupt requests, rising-edge sensitive
- gie  in  1  global interrupt enable
- mask_we  in  1  write strobe for mask register
- mask_din  in  NITR  mask write data (1 = enabled)
- branch  in  1  current instruction loads PC (JMP/taken JIZ/CAL/RET decode); must not include itr
- isp_push  in  1  return-stack push strobe (CAL)
- isp_pop  in  1  return-stack pop strobe (RET)
- itr  out  1  interrupt fire, one cycle
- itr_addr  out  MINSTW  vector address, valid while itr=1
- in_service  out  1  ISR active
- itr_id  out  clog2(NITR) (min 1)  index of the source being/last serviced
- pend  out  NITR  pending flags
- mask  out  NITR  current mask register

Behaviour:
- Reset (rst=0 at clock edge):
  - state=IDLE; pend=0; mask=0; itr=0; in_service=0; itr_id=0; depth=0; entry_depth=0.
  - req history register is loaded with the current req, so a level already high does not create an edge.
  - Reset mid-service abandons the ISR silently.
- Edge detect:
  - pend[i] is set on a 0->1 transition of req[i] (req_q registered).
  - pend[i] is cleared only when source i fires.
  - If the clear and a new edge on the same bit land in the same cycle, the set wins.
- Mask: mask_we loads mask_din at the clock edge; the new mask is effective the following cycle. Pend bits still latch while masked.
- eligible = gie & |(pend & mask). sel = lowest index i with pend[i] & mask[i]. Selection is fixed priority (0 highest).
- FSM:
  - IDLE: eligible -> ARM.
  - ARM:
    - itr = ~branch & eligible (combinational).
    - If itr:
      - itr_addr = ITRADD + sel*ITRSTEP, truncated to MINSTW bits.
      - At the edge: clear pend[sel], itr_id<=sel, entry_depth<=depth+1, state->SERVICE.
    - If eligible drops (gie low or mask change): -> IDLE.
    - If branch=1: hold ARM and retry each cycle. sel is re-evaluated each cycle, so a higher-priority arrival wins.
  - SERVICE:
    - in_service=1; no new fire (non-nested).
    - When isp_pop=1 and depth==entry_depth: -> IDLE, in_service=0 at the next cycle.
- Depth counter:
  - depth += (isp_push|itr) - isp_pop each cycle; push and pop together give net 0.
  - Wraps modulo 2^DEPW; stack overflow is out of scope.
  - itr counts as a push because the core stores the return address on interrupt entry.
- itr_addr = ITRADD when itr=0.
- Latency: a req edge at cycle n sets pend at n+1, enters ARM at n+2, and fires itr at n+2 at the earliest.

Decomposition:
- Shared package (sapho_pkg): opcode constants JMP=12, JIZ=13, CAL=14, RET=15; FSM state encoding for IDLE/ARM/SERVICE; the `clog2` function.
- One sub-module, prio_enc: parameterised lowest-index priority encoder producing a valid flag and an index. Everything else stays in itr_ctrl.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 for 2 cycles, release -> pend=0, mask=0, itr never asserts; req stays high with no edge, so pend stays 0.
- Basic fire: mask=4'b0100, gie=1, pulse req[2] at cycle 10 -> itr=1 at cycle 12, itr_addr=8, itr_id=2, pend[2]=0, in_service=1 from cycle 13.
- Priority and deferral:
  - Set pend[3] and pend[1] together, mask=4'hF, with branch=1 for 3 cycles -> itr held low.
  - First itr after branch falls has itr_addr=4 (source 1); pend[3] stays 1.
- Nested calls inside ISR: after entry, issue CAL, CAL, RET, RET, then RET -> in_service clears only after the third RET; pend[3] then fires, itr_addr=12.
- Masked and gie gating:
  - req[0] edge with mask[0]=0 -> pend[0]=1, no itr.
  - Write mask=1 -> fires 2 cycles later.
  - With gie=0 nothing fires until gie=1.
- Reset mid-service: rst=0 while in_service=1 -> in_service=0 and depth=0; after release a new req[0] edge is serviced normally.
